nbody_step_seq: RTL and testbench

- Parametrised successor controller for the N-body accelerator.
- Owns the Avalon-style register interface, the software load/readback path, and the address/write-enable sequencing for both passes of each step:
  - velocity kick pass over all ordered pairs i≠j;
  - position drift pass over all bodies.
- Runs a programmable number of steps per go, with abort, error checking, a half-kick flag on the first step, and an interrupt.
- The accel datapath, adders and body RAMs are external; this block only sequences them.

---
 rtl/nbody_step_seq.sv | 264 ++++++++++++++++++++++++++
 tb/tb_nbody_step_seq.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/nbody_step_seq.sv
// nbody_step_seq: bus registers, software load/readback and the
// kick/drift address sequencing for the N-body accelerator.
module nbody_step_seq #(
  parameter int BODIES     = 512,
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 16,
  parameter int BAW        = $clog2(BODIES),
  parameter int RAM_LAT    = 1,
  parameter int ACCL_LAT   = 122,
  parameter int ADD_LAT    = 20,
  parameter int MIN_BODIES = ADD_LAT + 2,
  parameter int STEP_W     = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  chipselect,
  input  logic                  read,
  input  logic                  write,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] writedata,
  output logic [DATA_WIDTH-1:0] readdata,
  output logic                  irq,
  input  logic [DATA_WIDTH-1:0] x_q,
  input  logic [DATA_WIDTH-1:0] y_q,
  output logic [BAW-1:0]        p_addr_i,
  output logic [BAW-1:0]        p_addr_j,
  output logic [BAW-1:0]        m_addr,
  output logic [BAW-1:0]        v_rd_addr,
  output logic [BAW-1:0]        v_wr_addr,
  output logic                  v_wren,
  output logic [BAW-1:0]        p_wr_addr,
  output logic                  p_wren,
  output logic                  kick_valid,
  output logic                  half_kick,
  output logic [4:0]            sw_wren
);
  localparam int D  = RAM_LAT + ACCL_LAT + ADD_LAT;
  localparam int P  = RAM_LAT + ADD_LAT;
  localparam int CW = $clog2(D + 1);
  localparam int IW = BAW + 1;

  localparam logic [IW-1:0] NMIN = IW'(MIN_BODIES);
  localparam logic [IW-1:0] NMAX = IW'(BODIES);

  localparam logic [6:0] FN_CTRL  = 7'h00;
  localparam logic [6:0] FN_N     = 7'h02;
  localparam logic [6:0] FN_X     = 7'h03;
  localparam logic [6:0] FN_Y     = 7'h04;
  localparam logic [6:0] FN_M     = 7'h05;
  localparam logic [6:0] FN_VX    = 7'h06;
  localparam logic [6:0] FN_VY    = 7'h07;
  localparam logic [6:0] FN_STEPS = 7'h08;
  localparam logic [6:0] FN_STAT  = 7'h40;
  localparam logic [6:0] FN_XQ    = 7'h41;
  localparam logic [6:0] FN_YQ    = 7'h42;
  localparam logic [6:0] FN_CNT   = 7'h43;

  typedef enum logic [2:0] {
    IDLE, ACCEL, ACCEL_DRAIN, POS, POS_DRAIN
  } state_t;

  state_t state, state_n;

  logic [6:0]        fn;
  logic [BAW-1:0]    a;
  logic              wr, rd, ctrl_wr;
  logic              busy, cfg_ok, start, stop;
  logic [IW-1:0]     n_bodies;
  logic [STEP_W-1:0] steps, step_count;
  logic              done, err, irq_en;
  logic [IW-1:0]     i, j, k, j1, jn;
  logic              wrap, last_pair;
  logic [CW-1:0]     cnt;
  logic              step_end, final_step;
  logic [D-1:0]      vd;
  logic [IW-1:0]     jd [D];
  logic [P-1:0]      pv;
  logic [IW-1:0]     pk [P];
  logic              unused_bits;

  assign fn      = addr[ADDR_WIDTH-1 -: 7];
  assign a       = addr[BAW-1:0];
  assign wr      = chipselect & write;
  assign rd      = chipselect & read;
  assign ctrl_wr = wr && fn == FN_CTRL;
  assign busy    = state != IDLE;
  assign cfg_ok  = n_bodies >= NMIN && n_bodies <= NMAX
                && steps != '0;
  assign start   = ctrl_wr & writedata[0] & ~busy;
  // Clearing go while running is treated the same as abort.
  assign stop    = ctrl_wr & busy & (writedata[1] | ~writedata[0]);

  assign step_end   = state == POS_DRAIN && cnt == '0;
  assign final_step = step_count + 1'b1 == steps;

  assign irq        = done & irq_en;
  assign kick_valid = vd[RAM_LAT+ACCL_LAT-1];
  assign v_wren     = vd[D-1];
  assign p_wren     = pv[P-1];
  assign half_kick  = (state == ACCEL || state == ACCEL_DRAIN)
                   && step_count == '0;

  assign unused_bits = ^writedata[DATA_WIDTH-1:STEP_W];

  // Next pair with the diagonal skipped in the same cycle.
  always_comb begin
    j1        = j + 1'b1;
    jn        = (j1 == i) ? j + IW'(2) : j1;
    wrap      = jn >= n_bodies;
    last_pair = wrap && (i + 1'b1 == n_bodies);
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:        if (start && cfg_ok) state_n = ACCEL;
      ACCEL:       if (last_pair) state_n = ACCEL_DRAIN;
      ACCEL_DRAIN: if (cnt == '0) state_n = POS;
      POS:         if (k == n_bodies - 1'b1) state_n = POS_DRAIN;
      POS_DRAIN:   if (cnt == '0) state_n = final_step ? IDLE : ACCEL;
      default:     state_n = IDLE;
    endcase
    if (stop) state_n = IDLE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      i     <= '0;
      j     <= '0;
      k     <= '0;
      cnt   <= '0;
      vd    <= '0;
      pv    <= '0;
      for (int n = 0; n < D; n++) jd[n] <= '0;
      for (int n = 0; n < P; n++) pk[n] <= '0;
    end else begin
      state <= state_n;
      vd    <= {vd[D-2:0], state == ACCEL};
      pv    <= {pv[P-2:0], state == POS};
      jd[0] <= j;
      pk[0] <= k;
      for (int n = 1; n < D; n++) jd[n] <= jd[n-1];
      for (int n = 1; n < P; n++) pk[n] <= pk[n-1];
      unique case (state)
        IDLE: begin
          i <= '0;
          j <= IW'(1);
        end
        ACCEL: begin
          if (last_pair) begin
            cnt <= CW'(D - 1);
          end else if (wrap) begin
            i <= i + 1'b1;
            j <= '0;
          end else begin
            j <= jn;
          end
        end
        ACCEL_DRAIN: begin
          cnt <= cnt - 1'b1;
          k   <= '0;
        end
        POS: begin
          k   <= k + 1'b1;
          cnt <= CW'(P - 1);
        end
        POS_DRAIN: begin
          cnt <= cnt - 1'b1;
          i   <= '0;
          j   <= IW'(1);
        end
      endcase
      if (stop) begin
        vd <= '0;
        pv <= '0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      readdata   <= '0;
      n_bodies   <= '0;
      steps      <= '0;
      step_count <= '0;
      irq_en     <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
    end else begin
      if (wr && !busy && fn == FN_N)
        n_bodies <= writedata[IW-1:0];
      if (wr && !busy && fn == FN_STEPS)
        steps <= writedata[STEP_W-1:0];
      if (ctrl_wr)
        irq_en <= writedata[2];
      if (start) begin
        err <= ~cfg_ok;
        if (cfg_ok) begin
          done       <= 1'b0;
          step_count <= '0;
        end
      end
      if (stop)
        done <= 1'b0;
      if (step_end && !stop) begin
        step_count <= step_count + 1'b1;
        if (final_step) done <= 1'b1;
      end
      if (rd) begin
        unique case (fn)
          FN_STAT: readdata <= DATA_WIDTH'({err, busy, done});
          FN_XQ:   readdata <= x_q;
          FN_YQ:   readdata <= y_q;
          FN_CNT:  readdata <= DATA_WIDTH'(step_count);
          default: readdata <= '1;
        endcase
      end
    end
  end

  always_comb begin
    sw_wren = '0;
    if (wr && !busy) begin
      unique case (fn)
        FN_X:    sw_wren = 5'b00001;
        FN_Y:    sw_wren = 5'b00010;
        FN_M:    sw_wren = 5'b00100;
        FN_VX:   sw_wren = 5'b01000;
        FN_VY:   sw_wren = 5'b10000;
        default: sw_wren = '0;
      endcase
    end
  end

  always_comb begin
    p_addr_i  = a;
    p_addr_j  = a;
    m_addr    = a;
    v_rd_addr = a;
    v_wr_addr = a;
    p_wr_addr = a;
    unique case (state)
      ACCEL, ACCEL_DRAIN: begin
        p_addr_i  = i[BAW-1:0];
        p_addr_j  = j[BAW-1:0];
        m_addr    = i[BAW-1:0];
        v_rd_addr = jd[ACCL_LAT-1][BAW-1:0];
        v_wr_addr = jd[D-1][BAW-1:0];
        p_wr_addr = pk[P-1][BAW-1:0];
      end
      POS, POS_DRAIN: begin
        p_addr_i  = pk[P-1][BAW-1:0];
        p_addr_j  = k[BAW-1:0];
        m_addr    = i[BAW-1:0];
        v_rd_addr = k[BAW-1:0];
        v_wr_addr = jd[D-1][BAW-1:0];
        p_wr_addr = pk[P-1][BAW-1:0];
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_nbody_step_seq.sv
// tb_nbody_step_seq: scoreboard bench for the N-body step sequencer,
// checking write-back pulses by cycle and address.
module tb_nbody_step_seq;
  localparam int D   = 143;
  localparam int P   = 21;
  localparam int BIG = 1 << 30;

  localparam logic [6:0] FN_CTRL  = 7'h00;
  localparam logic [6:0] FN_N     = 7'h02;
  localparam logic [6:0] FN_X     = 7'h03;
  localparam logic [6:0] FN_VY    = 7'h07;
  localparam logic [6:0] FN_STEPS = 7'h08;
  localparam logic [6:0] FN_STAT  = 7'h40;
  localparam logic [6:0] FN_XQ    = 7'h41;
  localparam logic [6:0] FN_YQ    = 7'h42;
  localparam logic [6:0] FN_CNT   = 7'h43;

  logic        clk = 1'b0;
  logic        rst;
  logic        chipselect, read, write;
  logic [15:0] addr;
  logic [63:0] writedata, readdata, x_q, y_q;
  logic        irq, v_wren, p_wren, kick_valid, half_kick;
  logic [8:0]  p_addr_i, p_addr_j, m_addr;
  logic [8:0]  v_rd_addr, v_wr_addr, p_wr_addr;
  logic [4:0]  sw_wren;

  always #5 clk = ~clk;

  nbody_step_seq dut (
    .clk(clk), .rst(rst),
    .chipselect(chipselect), .read(read), .write(write),
    .addr(addr), .writedata(writedata), .readdata(readdata),
    .irq(irq), .x_q(x_q), .y_q(y_q),
    .p_addr_i(p_addr_i), .p_addr_j(p_addr_j), .m_addr(m_addr),
    .v_rd_addr(v_rd_addr), .v_wr_addr(v_wr_addr), .v_wren(v_wren),
    .p_wr_addr(p_wr_addr), .p_wren(p_wren),
    .kick_valid(kick_valid), .half_kick(half_kick),
    .sw_wren(sw_wren)
  );

  typedef logic [63:0] ev_t;

  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  int   g = 0;
  int   kicks, hk_n, hk_first, hk_last, irq_rel;
  ev_t  vq[$], pq[$];
  ev_t  ve, pe;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  function automatic ev_t ev(input int c, input int x, input int y);
    return {32'(c), 16'(x), 16'(y)};
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (v_wren) begin
      ve = '1;
      if (vq.size() != 0) ve = vq.pop_front();
      chk("vwr", ev(cyc - g, int'(v_wr_addr), 0), ve);
    end
    if (p_wren) begin
      pe = '1;
      if (pq.size() != 0) pe = pq.pop_front();
      chk("pwr", ev(cyc - g, int'(p_wr_addr), int'(p_addr_i)), pe);
    end
    if (kick_valid) kicks++;
    if (half_kick) begin
      hk_n++;
      if (hk_first < 0) hk_first = cyc - g;
      hk_last = cyc - g;
    end
    if (irq && irq_rel < 0 && cyc - g > 0) irq_rel = cyc - g;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_wr(input logic [6:0] fn, input int idx,
                        input logic [63:0] d);
    chipselect = 1'b1; write = 1'b1;
    addr = {fn, 9'(idx)}; writedata = d;
    tick();
    chipselect = 1'b0; write = 1'b0; addr = '0;
  endtask

  task automatic wr_probe(input logic [6:0] fn, input int idx,
                          input logic [63:0] d, output logic [4:0] sw,
                          output logic [8:0] pa);
    chipselect = 1'b1; write = 1'b1;
    addr = {fn, 9'(idx)}; writedata = d;
    #1;
    sw = sw_wren;
    pa = p_addr_i;
    tick();
    chipselect = 1'b0; write = 1'b0; addr = '0;
  endtask

  task automatic bus_rd(input logic [6:0] fn, input int idx,
                        output logic [63:0] d);
    chipselect = 1'b1; read = 1'b1; addr = {fn, 9'(idx)};
    tick();
    chipselect = 1'b0; read = 1'b0; addr = '0;
    d = readdata;
  endtask

  // Expected write-backs relative to the go cycle, up to cycle lim.
  task automatic plan(input int n, input int steps, input int lim);
    int acc, len, t, r;
    acc = n * (n - 1);
    len = acc + D + n + P;
    vq.delete();
    pq.delete();
    for (int s = 0; s < steps; s++) begin
      t = 0;
      for (int i = 0; i < n; i++)
        for (int j = 0; j < n; j++)
          if (i != j) begin
            r = 1 + s * len + t + D;
            t++;
            if (r <= lim) vq.push_back(ev(r, j, 0));
          end
      for (int k = 0; k < n; k++) begin
        r = 1 + s * len + acc + D + k + P;
        if (r <= lim) pq.push_back(ev(r, k, k));
      end
    end
  endtask

  task automatic go_run(input int n, input int steps, input int lim,
                        input bit ien);
    bus_wr(FN_N, 0, 64'(n));
    bus_wr(FN_STEPS, 0, 64'(steps));
    plan(n, steps, lim);
    kicks = 0; hk_n = 0; hk_first = -1; hk_last = -1; irq_rel = -1;
    g = cyc;
    bus_wr(FN_CTRL, 0, {61'b0, ien, 2'b01});
  endtask

  logic [63:0] d;
  logic [4:0]  sw;
  logic [8:0]  pa;
  int          r;

  initial begin
    rst = 1'b1; chipselect = 1'b0; read = 1'b0; write = 1'b0;
    addr = '0; writedata = '0; x_q = '0; y_q = '0;
    kicks = 0; hk_n = 0; hk_first = -1; hk_last = -1; irq_rel = -1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_rd", readdata, 0);
    chk("rst_en", {irq, v_wren, p_wren, kick_valid, half_kick, sw_wren}, 0);
    chk("rst_addr", {p_addr_i, p_addr_j, m_addr,
                     v_rd_addr, v_wr_addr, p_wr_addr}, 0);
    rst = 1'b0;
    tick();
    bus_rd(FN_STAT, 0, d);  chk("stat_rst", d, 0);
    bus_rd(FN_CNT, 0, d);   chk("cnt_rst", d, 0);
    bus_rd(7'h55, 0, d);    chk("rd_other", d, '1);

    // Illegal configurations
    bus_wr(FN_N, 0, 16); bus_wr(FN_STEPS, 0, 1); bus_wr(FN_CTRL, 0, 1);
    bus_rd(FN_STAT, 0, d);  chk("err_n16", d, 4);
    bus_wr(FN_N, 0, 513); bus_wr(FN_CTRL, 0, 1);
    bus_rd(FN_STAT, 0, d);  chk("err_n513", d, 4);
    bus_wr(FN_N, 0, 32); bus_wr(FN_STEPS, 0, 0); bus_wr(FN_CTRL, 0, 1);
    bus_rd(FN_STAT, 0, d);  chk("err_s0", d, 4);

    // Main run N=32, two steps
    go_run(32, 2, BIG, 1'b1);
    while (irq_rel < 0 && cyc - g < 2600) begin
      r = cyc - g;
      if (r == 1)
        chk("iss1", {p_addr_i, p_addr_j, m_addr}, {9'd0, 9'd1, 9'd0});
      if (r == 32)
        chk("iss32", {p_addr_i, p_addr_j, m_addr}, {9'd1, 9'd0, 9'd1});
      if (r == 154) chk("vrd154", v_rd_addr, 0);
      if (r == 100) begin
        wr_probe(FN_X, 5, 64'hABCD, sw, pa);
        chk("sw_busy", sw, 0);
      end
      if (r == 200) begin
        bus_rd(FN_STAT, 0, d);
        chk("stat_busy", d, 2);
      end
      if (r == 300) bus_wr(FN_CTRL, 0, 64'h5);
      if (r == 2376) begin
        bus_rd(FN_STAT, 0, d);
        chk("stat_old", d, 2);
      end
      tick();
    end
    chk("done_cyc", irq_rel, 2377);
    chk("irq_on", irq, 1);
    chk("vq_left", vq.size(), 0);
    chk("pq_left", pq.size(), 0);
    chk("kicks", kicks, 1984);
    chk("hk_n", hk_n, 1135);
    chk("hk_span", {32'(hk_first), 32'(hk_last)}, {32'd1, 32'd1135});
    bus_rd(FN_STAT, 0, d);  chk("stat_done", d, 1);
    bus_rd(FN_CNT, 0, d);   chk("cnt_2", d, 2);

    // Software load and readback in IDLE
    wr_probe(FN_X, 5, 64'hABCD, sw, pa);
    chk("sw_x", sw, 5'b00001);
    chk("sw_addr", pa, 5);
    wr_probe(FN_VY, 7, 64'h1, sw, pa);
    chk("sw_vy", sw, 5'b10000);
    x_q = 64'h0123_4567_89AB_CDEF;
    y_q = 64'hFEDC_BA98_7654_3210;
    bus_rd(FN_XQ, 5, d);    chk("rd_x", d, 64'h0123_4567_89AB_CDEF);
    bus_rd(FN_YQ, 5, d);    chk("rd_y", d, 64'hFEDC_BA98_7654_3210);

    // Abort at cycle 500
    go_run(32, 1, 500, 1'b1);
    chk("irq_fall", irq, 0);
    while (cyc - g < 500) tick();
    bus_wr(FN_CTRL, 0, 64'h7);
    bus_rd(FN_STAT, 0, d);  chk("stat_abort", d, 0);
    bus_rd(FN_CNT, 0, d);   chk("cnt_abort", d, 0);
    repeat (200) tick();
    chk("vq_abort", vq.size(), 0);

    // N=512 accepted, then stopped by writing go=0
    go_run(512, 1, 300, 1'b0);
    while (cyc - g < 300) begin
      if (cyc - g == 150) begin
        bus_rd(FN_STAT, 0, d);
        chk("stat_512", d, 2);
      end else begin
        tick();
      end
    end
    bus_wr(FN_CTRL, 0, 64'h0);
    repeat (200) tick();
    chk("vq_512", vq.size(), 0);
    bus_rd(FN_STAT, 0, d);  chk("stat_go0", d, 0);

    // Reset in the middle of the kick pass
    go_run(32, 1, 399, 1'b0);
    while (cyc - g < 400) tick();
    #2 rst = 1'b1;
    #1;
    chk("rstmid_en", {irq, v_wren, p_wren, kick_valid, half_kick, sw_wren}, 0);
    chk("rstmid_rd", readdata, 0);
    tick();
    rst = 1'b0;
    tick();
    chk("vq_rst", vq.size(), 0);
    bus_rd(FN_STAT, 0, d);  chk("stat_rstmid", d, 0);

    // Smallest legal N, one step
    go_run(22, 1, BIG, 1'b1);
    while (irq_rel < 0 && cyc - g < 900) tick();
    chk("done22", irq_rel, 649);
    chk("vq22", vq.size(), 0);
    chk("pq22", pq.size(), 0);
    chk("kicks22", kicks, 462);
    chk("hk22", hk_n, 605);
    bus_rd(FN_CNT, 0, d);   chk("cnt22", d, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
